// File: rtl/reg_dump_reader.sv
// Register file dump engine: walks registers 0..NUM_REGS-1 through one read port and
// streams (index, data) beats. Define REG_DUMP_CHECKSUM_EN to append an XOR checksum beat.
module reg_dump_reader #(
  parameter int NUM_REGS = 32,
  parameter int ADDR_W   = 5,
  parameter int DATA_W   = 32
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] reg_read,
  input  logic [DATA_W-1:0] read_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ADDR_W-1:0] out_index,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last,
  output logic              out_is_csum,
  output logic [2:0]        fsm_state
);

  localparam logic [2:0] IDLE = 3'd0;
  localparam logic [2:0] LOAD = 3'd1;
  localparam logic [2:0] SEND = 3'd2;
  localparam logic [2:0] DONE = 3'd3;
`ifdef REG_DUMP_CHECKSUM_EN
  localparam logic [2:0] CSUM = 3'd4;
`endif

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_REGS - 1);

  logic [2:0]        state;
  logic [ADDR_W-1:0] idx;

  // Stream handshake: a beat transfers on any rising edge where out_valid and
  // out_ready are both high; while out_valid is high and out_ready is low the
  // beat fields (out_index, out_data, out_last, out_is_csum) do not change.
`ifdef REG_DUMP_CHECKSUM_EN
  logic [DATA_W-1:0] csum;
  logic              is_csum;
  assign out_is_csum = is_csum;
  assign out_valid   = (state == SEND) || (state == CSUM);
  assign busy        = (state == LOAD) || (state == SEND) || (state == CSUM);
`else
  assign out_is_csum = 1'b0;
  assign out_valid   = (state == SEND);
  assign busy        = (state == LOAD) || (state == SEND);
`endif

  assign done      = (state == DONE);
  assign reg_read  = (state == LOAD) ? idx : '0;
  assign fsm_state = state;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      idx       <= '0;
      out_index <= '0;
      out_data  <= '0;
      out_last  <= 1'b0;
`ifdef REG_DUMP_CHECKSUM_EN
      csum      <= '0;
      is_csum   <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            idx   <= '0;
            state <= LOAD;
`ifdef REG_DUMP_CHECKSUM_EN
            csum  <= '0;
`endif
          end
        end
        LOAD: begin
          out_data  <= read_data;
          out_index <= idx;
`ifdef REG_DUMP_CHECKSUM_EN
          out_last  <= 1'b0;
          csum      <= csum ^ read_data;
`else
          out_last  <= (idx == LAST_IDX);
`endif
          state     <= SEND;
        end
        SEND: begin
          if (out_ready) begin
            // idx only advances below the last index, so the read address never wraps
            if (idx < LAST_IDX) begin
              idx   <= idx + 1'b1;
              state <= LOAD;
            end else begin
`ifdef REG_DUMP_CHECKSUM_EN
              out_data  <= csum;
              out_index <= '0;
              out_last  <= 1'b1;
              is_csum   <= 1'b1;
              state     <= CSUM;
`else
              state     <= DONE;
`endif
            end
          end
        end
`ifdef REG_DUMP_CHECKSUM_EN
        CSUM: begin
          if (out_ready) begin
            is_csum <= 1'b0;
            state   <= DONE;
          end
        end
`endif
        DONE: begin
          out_last <= 1'b0;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/reg_dump_reader.md
Name: reg_dump_reader

Overview:
- Debug/readback engine on the read side of the CPU register file.
- On a start pulse it walks the register file through one read port, from register 0 to NUM_REGS-1.
- Each value is captured into a holding register and emitted as a valid/ready stream of (index, data) beats.
- The stream feeds the debug/trace path, so a testbench or host can snapshot architectural state without halting the write side.

Parameters:
- NUM_REGS, 32, number of registers dumped (indices 0..NUM_REGS-1); NUM_REGS <= 2**ADDR_W.
- ADDR_W, 5, width of register index and read address.
- DATA_W, 32, register data width.

Ports:
- clock  input  1  single clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  single-cycle request to begin a dump; sampled only in IDLE.
- busy  output  1  high from the cycle after start is accepted until the cycle done is asserted.
- done  output  1  one-cycle pulse after the final beat is accepted.
- reg_read  output  ADDR_W  read address driven to the register file read port.
- read_data  input  DATA_W  combinational read data returned by the register file.
- out_valid  output  1  stream beat valid.
- out_ready  input  1  stream consumer ready.
- out_index  output  ADDR_W  register index of the current beat.
- out_data  output  DATA_W  captured register value of the current beat.
- out_last  output  1  marks the final beat of a dump.
- out_is_csum  output  1  marks a checksum beat; tied 0 when REG_DUMP_CHECKSUM_EN is undefined.

Behaviour:
- Reset values: busy=0, done=0, reg_read=0, out_valid=0, out_index=0, out_data=0, out_last=0, out_is_csum=0, idx=0, state=IDLE.
- FSM states: IDLE, LOAD, SEND, DONE.
- IDLE:
  - reg_read=0.
  - start=1 -> idx<=0, go to LOAD.
  - start=0 -> stay in IDLE.
- LOAD (exactly one cycle):
  - reg_read=idx.
  - At the clock edge: out_data<=read_data, out_index<=idx, out_last<=(idx==NUM_REGS-1 and checksum disabled).
  - Go to SEND.
- SEND:
  - out_valid=1; out_index, out_data and out_last are held stable while out_ready=0.
  - A beat transfers on a cycle with out_valid and out_ready both high.
  - On transfer with idx<NUM_REGS-1: idx<=idx+1, go to LOAD.
  - On transfer of the last register beat: go to DONE (or CSUM, see Optional Feature).
- DONE:
  - done=1 for one cycle, out_valid=0, then go to IDLE.
  - busy drops in the same cycle that done=1.
- Throughput and latency:
  - One beat per 2 cycles at best, because LOAD and SEND alternate.
  - start sampled at edge 0 -> LOAD in cycle 1 -> first out_valid=1 in cycle 2.
  - Full dump with out_ready always 1: done pulses in cycle 2*NUM_REGS+1 after the start edge.
- Data capture:
  - Each value is sampled in its LOAD cycle.
  - A register write landing after that edge is not reflected in that beat.
  - A write to a not-yet-read register during the dump is reflected when that register is read.
- start while busy is ignored; it does not restart the dump and is not queued.
- out_ready may be high while out_valid=0 with no effect.
- Reset asserted mid-dump:
  - Immediately forces all reset values.
  - No done pulse, no partial out_last.
  - A new start after reset begins again at index 0.
- idx saturates at NUM_REGS-1 and never wraps to drive an out-of-range address.

Optional Feature:
- Macro: REG_DUMP_CHECKSUM_EN.
- When defined:
  - An accumulator csum (DATA_W) is cleared to 0 on start acceptance.
  - csum is XORed with each register value as that value is captured in LOAD.
  - After the last register beat transfers, state CSUM presents out_valid=1, out_data=csum, out_index=0, out_is_csum=1, out_last=1.
  - The register beat for NUM_REGS-1 then has out_last=0.
  - Transfer of the checksum beat goes to DONE.
  - Total dump is NUM_REGS+1 beats; done pulses one cycle later than without the feature.
- When undefined:
  - No CSUM state and no accumulator; out_is_csum is constant 0.
  - out_last is set on the index NUM_REGS-1 beat.

Test Plan:
- Register i preloaded with 32'h100+i, out_ready held 1, pulse start -> 32 beats with index i and data 32'h100+i in order; first out_valid 2 cycles after start; out_last only on index 31; done one cycle after the last transfer.
- out_ready toggling (low 3 cycles per beat) -> out_index/out_data stable while out_valid=1 and out_ready=0; no beat lost or duplicated; still 32 beats.
- start pulsed again at beat 10 -> ignored; sequence continues at index 11; exactly one done.
- Reset asserted while beat 5 is waiting on out_ready=0 -> next cycle out_valid=0, busy=0, no done; new start yields index 0 first.
- Register 20 written with 32'hDEAD_BEEF while beat 3 is in SEND -> beat 20 carries 32'hDEAD_BEEF; beat 3 carries its pre-write value.
- REG_DUMP_CHECKSUM_EN defined, registers = 32'h100+i -> 33rd beat has out_is_csum=1, out_last=1, out_data=XOR of all 32 values (32'h0), and beat 31 has out_last=0.
